// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_pkg                                                                     |
// | Shared types, tag layout and sizing helper for the frame-buffer scanout.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_e;

    // Tag travelling alongside each outstanding read
    localparam int c_tag_valid = 0;
    localparam int c_tag_sof   = 1;
    localparam int c_tag_eof   = 2;
    localparam int c_tag_w     = 3;

    // ceil(log2(value)), never below 1 so it can size a vector directly
    function automatic int fb_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(value)) begin
                r = r + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_sync_fifo                                                               |
// | Show-ahead synchronous FIFO with registered storage and occupancy count.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_sync_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              pop_data_o,
    output logic                          empty_o,
    output logic [fb_clog2(DEPTH+1)-1:0]  count_o
);

    localparam int c_ptr_w = fb_clog2(DEPTH);
    localparam int c_cnt_w = fb_clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_pop_ok;

    assign w_pop_ok   = pop_i && (r_count != '0);
    assign empty_o    = (r_count == '0);
    assign count_o    = r_count;
    assign pop_data_o = r_mem[r_rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        always_ff @(posedge clk_i or negedge resetn_i) begin
            if (!resetn_i) begin
                r_mem[i] <= '0;
            end else if (push_i && (r_wr_ptr == c_ptr_w'(i))) begin
                r_mem[i] <= push_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            case ({push_i, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_scanout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_scanout_ctrl                                                            |
// | Walks a frame of frame_buffer addresses and streams pixels with sof/eof.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_scanout_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_PIXELS = 4096,
    parameter int BASE_ADDR    = 0,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [ADDR_WIDTH-1:0] addr_rd_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_sof_o,
    output logic                  m_eof_o
);

    localparam int c_cnt_w  = fb_clog2(FRAME_PIXELS + 1);
    localparam int c_inf_w  = fb_clog2(RD_LATENCY + 1);
    localparam int c_fcnt_w = fb_clog2(FIFO_DEPTH + 1);
    localparam int c_ent_w  = DATA_WIDTH + 2;
    localparam logic [c_cnt_w-1:0]    c_frame_pix = c_cnt_w'(FRAME_PIXELS);
    localparam logic [c_cnt_w-1:0]    c_last_pix  = c_cnt_w'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_base      = ADDR_WIDTH'(BASE_ADDR);

    fb_state_e                          r_state;
    fb_state_e                          w_state_nxt;
    logic                               r_aborted;
    logic                               w_aborted_nxt;
    logic                               w_start_acc;
    logic [c_cnt_w-1:0]                 r_pix_cnt;
    logic [ADDR_WIDTH-1:0]              r_addr;
    logic [RD_LATENCY-1:0][c_tag_w-1:0] r_tag;
    logic [c_inf_w-1:0]                 r_inflight;
    logic [c_tag_w-1:0]                 w_new_tag;
    logic                               w_issue;
    logic                               w_credit_ok;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_fifo_empty;
    logic                               w_drain_done;
    logic [c_fcnt_w-1:0]                w_fifo_count;
    logic [c_ent_w-1:0]                 w_push_entry;
    logic [c_ent_w-1:0]                 w_pop_entry;

    // Every read in the tag pipe has a FIFO slot reserved, so the FIFO cannot overflow
    assign w_credit_ok  = (int'(r_inflight) + int'(w_fifo_count)) < FIFO_DEPTH;
    assign w_issue      = (r_state == ST_RUN) && (r_pix_cnt < c_frame_pix) &&
                          !stop_i && w_credit_ok;
    assign w_push       = r_tag[RD_LATENCY-1][c_tag_valid];
    assign w_push_entry = {r_tag[RD_LATENCY-1][c_tag_eof],
                           r_tag[RD_LATENCY-1][c_tag_sof], rd_data_i};
    assign w_pop        = !w_fifo_empty && m_ready_i;
    assign w_drain_done = (r_inflight == '0) && w_fifo_empty;

    assign busy_o       = (r_state != ST_IDLE);
    assign frame_done_o = (r_state == ST_DRAIN) && w_drain_done && !r_aborted;
    assign addr_rd_o    = r_addr;
    assign m_valid_o    = !w_fifo_empty;
    assign {m_eof_o, m_sof_o, m_data_o} = w_pop_entry;

    always_comb begin
        w_new_tag              = '0;
        w_new_tag[c_tag_valid] = w_issue;
        w_new_tag[c_tag_sof]   = (r_pix_cnt == '0);
        w_new_tag[c_tag_eof]   = (r_pix_cnt == c_last_pix);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_aborted_nxt = r_aborted;
        w_start_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt   = ST_RUN;
                    w_aborted_nxt = 1'b0;
                    w_start_acc   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_state_nxt   = ST_DRAIN;
                    w_aborted_nxt = 1'b1;
                end else if (w_issue && (r_pix_cnt == c_last_pix)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= ST_IDLE;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_pix_cnt <= '0;
            r_addr    <= '0;
        end else begin
            if (w_start_acc) begin
                r_pix_cnt <= '0;
            end else if (w_issue) begin
                r_pix_cnt <= r_pix_cnt + c_cnt_w'(1);
            end
            if (w_issue) begin
                r_addr <= c_base + ADDR_WIDTH'(r_pix_cnt);
            end
        end
    end

    // Tag exits the last stage exactly when the buffer's read data is valid
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_tag      <= '0;
            r_inflight <= '0;
        end else begin
            r_tag[0] <= w_new_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + c_inf_w'(1);
                2'b01:   r_inflight <= r_inflight - c_inf_w'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    fb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ent_w)
    ) u_fifo (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .pop_data_o  (w_pop_entry),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fb_scanout_ctrl                                                         |
// | Directed bench: four scanout configurations against a 2-cycle buffer model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fb_scanout_ctrl;

    localparam int FP [4] = '{16, 8, 4, 64};
    localparam int BA [4] = '{0, 'h3FC, 'hFFE, 0};

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  start, stop, ready;
    logic [3:0]  busy, done, valid, sof, eof;
    logic [11:0] addr [4];
    logic [15:0] data [4];
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [15:0] rdq;
        // Buffer model: mem[a] = a ^ 0x5A00, address registered then data registered
        always @(posedge clk) rdq <= {4'h0, addr[g]} ^ 16'h5A00;

        fb_scanout_ctrl #(
            .ADDR_WIDTH(12), .DATA_WIDTH(16), .FRAME_PIXELS(FP[g]),
            .BASE_ADDR(BA[g]), .RD_LATENCY(2), .FIFO_DEPTH(4)
        ) u_dut (
            .clk_i(clk), .resetn_i(resetn), .start_i(start[g]), .stop_i(stop[g]),
            .busy_o(busy[g]), .frame_done_o(done[g]), .addr_rd_o(addr[g]),
            .rd_data_i(rdq), .m_valid_o(valid[g]), .m_ready_i(ready[g]),
            .m_data_o(data[g]), .m_sof_o(sof[g]), .m_eof_o(eof[g])
        );
    end

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          cur = 0;
    int          t0 = 0;
    logic [17:0] bq [$];
    int          bc [$];
    logic [11:0] aq [$];
    int          dq [$];
    logic [11:0] last_addr;

    always @(negedge clk) begin
        if (valid[cur] && ready[cur]) begin
            bq.push_back({eof[cur], sof[cur], data[cur]});
            bc.push_back(cyc);
        end
        if (addr[cur] != last_addr) begin
            aq.push_back(addr[cur]);
            last_addr = addr[cur];
        end
        if (done[cur]) dq.push_back(cyc);
    end

    task automatic clear_logs(input int idx);
        cur = idx;
        bq.delete(); bc.delete(); aq.delete(); dq.delete();
        last_addr = addr[idx];
    endtask

    task automatic pulse_start(input int idx, input logic with_stop);
        @(posedge clk); #1;
        start[idx] = 1'b1; stop[idx] = with_stop;
        @(posedge clk); #1;
        start[idx] = 1'b0; stop[idx] = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && bq.size() < n; i++) begin
            @(posedge clk); #1;
        end
        ok = (bq.size() >= n);
    endtask

    task automatic wait_idle(input int idx, input int budget, output bit ok);
        for (int i = 0; i < budget && busy[idx]; i++) begin
            @(posedge clk); #1;
        end
        ok = !busy[idx];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if ({busy[k], valid[k], done[k], sof[k], eof[k]} !== 5'b0) begin
                miss_cnt++;
                $display("FAIL reset_flags[%0d]: got %b expected 00000", k,
                         {busy[k], valid[k], done[k], sof[k], eof[k]});
            end
            vec_cnt++;
            if ({addr[k], data[k]} !== 28'h0) begin
                miss_cnt++;
                $display("FAIL reset_addr_data[%0d]: got %h expected 0", k, {addr[k], data[k]});
            end
        end
    endtask

    task automatic test_frame();
        bit ok, ok2;
        logic [17:0] exp;
        clear_logs(0);
        ready[0] = 1'b1;
        pulse_start(0, 1'b0);
        wait_beats(16, 60, ok);
        wait_idle(0, 20, ok2);
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 16) begin
            miss_cnt++;
            $display("FAIL frame_beats: got %0d expected 16 (timeout=%0d)", bq.size(), !(ok && ok2));
        end
        for (int i = 0; i < 16 && i < bq.size(); i++) begin
            exp = {i == 15, i == 0, 16'(i) ^ 16'h5A00};
            vec_cnt++;
            if (bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL frame_beat[%0d]: got %h expected %h", i, bq[i], exp);
            end
        end
        vec_cnt++;
        if (bc.size() != 16 || bc[0] != t0 + 3 || bc[15] != t0 + 18) begin
            miss_cnt++;
            $display("FAIL frame_timing: got first=%0d last=%0d expected %0d %0d",
                     (bc.size() > 0) ? bc[0] - t0 : -1, (bc.size() == 16) ? bc[15] - t0 : -1, 3, 18);
        end
        vec_cnt++;
        if (dq.size() != 1 || dq[0] != t0 + 19) begin
            miss_cnt++;
            $display("FAIL frame_done: got count=%0d at=%0d expected 1 at 19", dq.size(),
                     (dq.size() > 0) ? dq[0] - t0 : -1);
        end
        vec_cnt++;
        if (cyc != t0 + 20) begin
            miss_cnt++;
            $display("FAIL frame_busy_fall: got %0d expected 20", cyc - t0);
        end
    endtask

    task automatic test_stall();
        bit ok, ok2;
        logic [19:0] ref_out;
        logic [11:0] ref_addr;
        int          unstable;
        logic [17:0] exp;
        clear_logs(0);
        ready[0] = 1'b1;
        pulse_start(0, 1'b0);
        wait_beats(4, 30, ok);
        ready[0] = 1'b0;
        unstable = 0;
        ref_out  = '0;
        ref_addr = '0;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (s == 0) ref_out = {valid[0], eof[0], sof[0], 1'b0, data[0]};
            else if ({valid[0], eof[0], sof[0], 1'b0, data[0]} !== ref_out) unstable++;
            if (s == 5) ref_addr = addr[0];
        end
        vec_cnt++;
        if (!ok || ref_out !== {4'b1000, 16'h5A04}) begin
            miss_cnt++;
            $display("FAIL stall_head: got %h expected %h", ref_out, {4'b1000, 16'h5A04});
        end
        vec_cnt++;
        if (unstable != 0) begin
            miss_cnt++;
            $display("FAIL stall_stable: got %0d changes expected 0", unstable);
        end
        vec_cnt++;
        if (addr[0] !== ref_addr) begin
            miss_cnt++;
            $display("FAIL stall_addr_frozen: got %h expected %h", addr[0], ref_addr);
        end
        @(posedge clk); #1;
        ready[0] = 1'b1;
        wait_beats(16, 60, ok);
        wait_idle(0, 20, ok2);
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 16 || dq.size() != 1) begin
            miss_cnt++;
            $display("FAIL stall_beats: got %0d beats %0d done expected 16 1", bq.size(), dq.size());
        end
        for (int i = 0; i < 16 && i < bq.size(); i++) begin
            exp = {i == 15, i == 0, 16'(i) ^ 16'h5A00};
            vec_cnt++;
            if (bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL stall_beat[%0d]: got %h expected %h", i, bq[i], exp);
            end
        end
    endtask

    task automatic test_bank_cross();
        bit ok, ok2;
        logic [11:0] a;
        logic [17:0] exp;
        clear_logs(1);
        ready[1] = 1'b1;
        pulse_start(1, 1'b0);
        wait_beats(8, 40, ok);
        wait_idle(1, 20, ok2);
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 8 || aq.size() != 8 || dq.size() != 1) begin
            miss_cnt++;
            $display("FAIL bank_counts: got beats=%0d addrs=%0d done=%0d expected 8 8 1",
                     bq.size(), aq.size(), dq.size());
        end
        for (int i = 0; i < 8 && i < bq.size() && i < aq.size(); i++) begin
            a   = 12'h3FC + 12'(i);
            exp = {i == 7, i == 0, {4'h0, a} ^ 16'h5A00};
            vec_cnt++;
            if (aq[i] !== a || bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL bank_beat[%0d]: got addr=%h beat=%h expected %h %h", i, aq[i], bq[i], a, exp);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok, ok2;
        logic [11:0] a;
        logic [17:0] exp;
        clear_logs(2);
        ready[2] = 1'b1;
        pulse_start(2, 1'b0);
        wait_beats(4, 30, ok);
        wait_idle(2, 20, ok2);
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 4 || aq.size() != 4 || dq.size() != 1) begin
            miss_cnt++;
            $display("FAIL wrap_counts: got beats=%0d addrs=%0d done=%0d expected 4 4 1",
                     bq.size(), aq.size(), dq.size());
        end
        for (int i = 0; i < 4 && i < bq.size() && i < aq.size(); i++) begin
            a   = 12'hFFE + 12'(i);
            exp = {i == 3, i == 0, {4'h0, a} ^ 16'h5A00};
            vec_cnt++;
            if (aq[i] !== a || bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL wrap_beat[%0d]: got addr=%h beat=%h expected %h %h", i, aq[i], bq[i], a, exp);
            end
        end
    endtask

    task automatic test_stop();
        bit ok, ok2;
        logic [17:0] exp;
        clear_logs(3);
        ready[3] = 1'b1;
        pulse_start(3, 1'b0);
        wait_beats(6, 40, ok);
        stop[3] = 1'b1;
        @(posedge clk); #1;
        stop[3] = 1'b0;
        wait_idle(3, 40, ok2);
        repeat (5) @(posedge clk);
        #1;
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 9) begin
            miss_cnt++;
            $display("FAIL stop_beats: got %0d expected 9 (timeout=%0d)", bq.size(), !(ok && ok2));
        end
        for (int i = 0; i < 9 && i < bq.size(); i++) begin
            exp = {1'b0, i == 0, 16'(i) ^ 16'h5A00};
            vec_cnt++;
            if (bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL stop_beat[%0d]: got %h expected %h", i, bq[i], exp);
            end
        end
        vec_cnt++;
        if (dq.size() != 0 || addr[3] !== 12'h008) begin
            miss_cnt++;
            $display("FAIL stop_done_addr: got done=%0d addr=%h expected 0 008", dq.size(), addr[3]);
        end
        clear_logs(3);
        pulse_start(3, 1'b0);
        wait_beats(64, 120, ok);
        wait_idle(3, 20, ok2);
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 64 || dq.size() != 1 || bc[0] != t0 + 3) begin
            miss_cnt++;
            $display("FAIL restart_counts: got beats=%0d done=%0d expected 64 1", bq.size(), dq.size());
        end
        for (int i = 0; i < 64 && i < bq.size(); i++) begin
            exp = {i == 63, i == 0, 16'(i) ^ 16'h5A00};
            vec_cnt++;
            if (bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL restart_beat[%0d]: got %h expected %h", i, bq[i], exp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok, ok2;
        logic [17:0] exp;
        clear_logs(0);
        ready[0] = 1'b1;
        pulse_start(0, 1'b0);
        wait_beats(3, 30, ok);
        resetn = 1'b0;
        #1;
        vec_cnt++;
        if (!ok || {busy[0], valid[0], done[0], sof[0], eof[0]} !== 5'b0) begin
            miss_cnt++;
            $display("FAIL midreset_flags: got %b expected 00000", {busy[0], valid[0], done[0], sof[0], eof[0]});
        end
        vec_cnt++;
        if ({addr[0], data[0]} !== 28'h0) begin
            miss_cnt++;
            $display("FAIL midreset_addr_data: got %h expected 0", {addr[0], data[0]});
        end
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_logs(0);
        pulse_start(0, 1'b1);
        wait_beats(16, 60, ok);
        wait_idle(0, 20, ok2);
        vec_cnt++;
        if (!(ok && ok2) || bq.size() != 16 || dq.size() != 1) begin
            miss_cnt++;
            $display("FAIL midreset_frame: got beats=%0d done=%0d expected 16 1", bq.size(), dq.size());
        end
        for (int i = 0; i < 16 && i < bq.size(); i++) begin
            exp = {i == 15, i == 0, 16'(i) ^ 16'h5A00};
            vec_cnt++;
            if (bq[i] !== exp) begin
                miss_cnt++;
                $display("FAIL midreset_beat[%0d]: got %h expected %h", i, bq[i], exp);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        start  = '0;
        stop   = '0;
        ready  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        test_frame();
        test_stall();
        test_bank_cross();
        test_wrap();
        test_stop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
`default_nettype wire
